// File: rtl/frequency_analyzer_pkg.sv
// Shared definitions for the frequency analyzer bank: sequencer state
// encoding, register-interface operation codes and a window-length helper.
package frequency_analyzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DUMP    = 3'd4,
        ST_NOTIFY  = 3'd5
    } mwc_state_t;

    // Operation codes understood by axi_slave_impl's register-write port.
    localparam logic [1:0] REGISTER_WRITE_OPERATION = 2'd2;
    localparam logic [1:0] REGISTER_NO_OPERATION    = 2'd0;

    // A programmed length of zero still opens a one-cycle window.
    function automatic logic [31:0] window_length(input logic [31:0] requested);
        return (requested == 32'd0) ? 32'd1 : requested;
    endfunction

endpackage

// File: rtl/measurement_timer.sv
// Loadable down counter. o_terminal is high while the count sits at 1, so a
// value N loaded on one edge makes the terminal edge the N-th one after it.
module measurement_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_terminal
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Load has priority over counting; the counter parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_terminal = (r_count == ONE);

endmodule

// File: rtl/measurement_window_controller.sv
// Sequencer for the analyzer bank: clear, timed measurement window, settle,
// serial dump of one result register per slot, then interrupt and wait for
// acknowledge. Single-shot and continuous (run held high) operation.
//
// Control inputs are plain pulses/levels sampled on the clock edge; there is
// no handshake. Every output is a register.
module measurement_window_controller
    import frequency_analyzer_pkg::*;
#(
    parameter int CLOCK_FREQUENCY    = 100000000,
    parameter int NUMBER_OF_CHANNELS = 7,
    parameter int SETTLE_CYCLES      = 4,
    parameter int HOLD_CYCLES        = 4
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic        run,
    input  logic        single_shot,
    input  logic        abort,
    input  logic        ack,
    input  logic [31:0] window_cycles,
    input  logic [31:0] result_value,
    output logic [7:0]  result_index,
    output logic        analyzer_enable,
    output logic        analyzer_clear_n,
    output logic [1:0]  register_operation,
    output logic [7:0]  register_number,
    output logic [31:0] register_write,
    output logic        irq,
    output logic        busy,
    output logic [15:0] window_count,
    output logic        overrun,
    output logic [2:0]  o_dbg_state
);

    // The clock frequency is documentation only; nothing is derived from it.
    if (CLOCK_FREQUENCY <= 0) begin : g_clock_frequency_unset
    end

    localparam logic [7:0]  LAST_SLOT = 8'(NUMBER_OF_CHANNELS);
    localparam logic [15:0] SETTLE_LEN = 16'(SETTLE_CYCLES);
    localparam logic [15:0] HOLD_LEN = 16'(HOLD_CYCLES);
    // With one-cycle slots the write is issued on the slot's only cycle.
    localparam bit HOLD_ONE = (HOLD_CYCLES == 1);

    mwc_state_t  r_state;
    logic [7:0]  r_slot;
    logic        r_slot_first;
    logic [7:0]  r_result_index;
    logic        r_enable;
    logic        r_clear_n;
    logic [1:0]  r_operation;
    logic [7:0]  r_register_number;
    logic [31:0] r_register_write;
    logic        r_irq;
    logic        r_busy;
    logic [15:0] r_window_count;
    logic        r_overrun;

    logic        w_win_load;
    logic        w_win_enable;
    logic [31:0] w_win_value;
    logic        w_win_tc;
    logic        w_settle_start;
    logic        w_slot_start;
    logic        w_phase_load;
    logic        w_phase_enable;
    logic [15:0] w_phase_value;
    logic        w_phase_tc;
    logic [7:0]  w_next_slot;

    // Timer controls: the window timer runs in MEASURE; the phase timer is
    // shared by SETTLE and each dump slot, reloaded at every phase change.
    always_comb begin
        w_win_load     = (r_state == ST_CLEAR);
        w_win_enable   = (r_state == ST_MEASURE);
        w_win_value    = window_length(window_cycles);
        w_settle_start = (r_state == ST_MEASURE) && w_win_tc;
        w_slot_start   = w_phase_tc && ((r_state == ST_SETTLE) ||
                         ((r_state == ST_DUMP) && (r_slot != LAST_SLOT)));
        w_phase_load   = w_settle_start || w_slot_start;
        w_phase_value  = w_settle_start ? SETTLE_LEN : HOLD_LEN;
        w_phase_enable = (r_state == ST_SETTLE) || (r_state == ST_DUMP);
        w_next_slot    = r_slot + 8'd1;
    end

    measurement_timer #(.WIDTH(32)) u_window_timer (
        .clk          (s00_axi_aclk),
        .rst_n        (s00_axi_aresetn),
        .i_load       (w_win_load),
        .i_load_value (w_win_value),
        .i_enable     (w_win_enable),
        .o_terminal   (w_win_tc)
    );

    measurement_timer #(.WIDTH(16)) u_phase_timer (
        .clk          (s00_axi_aclk),
        .rst_n        (s00_axi_aresetn),
        .i_load       (w_phase_load),
        .i_load_value (w_phase_value),
        .i_enable     (w_phase_enable),
        .o_terminal   (w_phase_tc)
    );

    // Main sequencer with registered outputs; abort wins over everything.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state           <= ST_IDLE;
            r_slot            <= 8'd0;
            r_slot_first      <= 1'b0;
            r_result_index    <= 8'd0;
            r_enable          <= 1'b0;
            r_clear_n         <= 1'b1;
            r_operation       <= REGISTER_NO_OPERATION;
            r_register_number <= 8'd0;
            r_register_write  <= 32'd0;
            r_irq             <= 1'b0;
            r_busy            <= 1'b0;
            r_window_count    <= 16'd0;
            r_overrun         <= 1'b0;
        end else begin
            r_operation <= REGISTER_NO_OPERATION;
            r_clear_n   <= 1'b1;
            if (ack) begin
                r_overrun <= 1'b0;
            end
            if (single_shot && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (abort) begin
                r_state           <= ST_IDLE;
                r_slot            <= 8'd0;
                r_slot_first      <= 1'b0;
                r_result_index    <= 8'd0;
                r_enable          <= 1'b0;
                r_register_number <= 8'd0;
                r_register_write  <= 32'd0;
                r_irq             <= 1'b0;
                r_busy            <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (run || single_shot) begin
                            r_state   <= ST_CLEAR;
                            r_clear_n <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        r_state  <= ST_MEASURE;
                        r_enable <= 1'b1;
                    end
                    ST_MEASURE: begin
                        // run falling is deliberately ignored here.
                        if (w_win_tc) begin
                            r_state  <= ST_SETTLE;
                            r_enable <= 1'b0;
                        end
                    end
                    ST_SETTLE, ST_DUMP: begin
                        // Data is captured once the index has been stable
                        // for a cycle, so the external mux has settled.
                        if (r_slot_first) begin
                            r_slot_first     <= 1'b0;
                            r_register_write <= result_value;
                            r_operation      <= REGISTER_WRITE_OPERATION;
                        end
                        if (w_slot_start) begin
                            r_state           <= ST_DUMP;
                            r_slot            <= w_next_slot;
                            r_result_index    <= w_next_slot;
                            r_register_number <= w_next_slot;
                            r_slot_first      <= !HOLD_ONE;
                            if (HOLD_ONE) begin
                                r_register_write <= result_value;
                                r_operation      <= REGISTER_WRITE_OPERATION;
                            end
                        end else if (w_phase_tc && (r_state == ST_DUMP)) begin
                            r_state           <= ST_NOTIFY;
                            r_slot            <= 8'd0;
                            r_result_index    <= 8'd0;
                            r_register_number <= 8'd0;
                            r_irq             <= 1'b1;
                            r_window_count    <= r_window_count + 16'd1;
                        end
                    end
                    ST_NOTIFY: begin
                        if (ack) begin
                            r_irq <= 1'b0;
                            if (run) begin
                                r_state   <= ST_CLEAR;
                                r_clear_n <= 1'b0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign result_index       = r_result_index;
    assign analyzer_enable    = r_enable;
    assign analyzer_clear_n   = r_clear_n;
    assign register_operation = r_operation;
    assign register_number    = r_register_number;
    assign register_write     = r_register_write;
    assign irq                = r_irq;
    assign busy               = r_busy;
    assign window_count       = r_window_count;
    assign overrun            = r_overrun;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_measurement_window_controller.sv
// Bench for measurement_window_controller: directed sequence with randomized
// window lengths and analyzer results, checked against timings derived from
// the sequencer's documented behaviour.
`timescale 1ns/1ps
module tb_measurement_window_controller;

    localparam int NCH    = 7;
    localparam int SETTLE = 4;
    localparam int HOLD   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        run = 1'b0;
    logic        single_shot = 1'b0;
    logic        abort = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] window_cycles = 32'd0;
    logic [31:0] result_value;
    logic [7:0]  result_index;
    logic        analyzer_enable;
    logic        analyzer_clear_n;
    logic [1:0]  register_operation;
    logic [7:0]  register_number;
    logic [31:0] register_write;
    logic        irq;
    logic        busy;
    logic [15:0] window_count;
    logic        overrun;
    logic [2:0]  dbg_state;

    // Analyzer bank model: result mux selected by result_index.
    logic [31:0] res_tab [0:255];
    always_comb result_value = res_tab[result_index];

    measurement_window_controller #(
        .CLOCK_FREQUENCY    (100000000),
        .NUMBER_OF_CHANNELS (NCH),
        .SETTLE_CYCLES      (SETTLE),
        .HOLD_CYCLES        (HOLD)
    ) dut (
        .s00_axi_aclk       (clk),
        .s00_axi_aresetn    (rst_n),
        .run                (run),
        .single_shot        (single_shot),
        .abort              (abort),
        .ack                (ack),
        .window_cycles      (window_cycles),
        .result_value       (result_value),
        .result_index       (result_index),
        .analyzer_enable    (analyzer_enable),
        .analyzer_clear_n   (analyzer_clear_n),
        .register_operation (register_operation),
        .register_number    (register_number),
        .register_write     (register_write),
        .irq                (irq),
        .busy               (busy),
        .window_count       (window_count),
        .overrun            (overrun),
        .o_dbg_state        (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int exp_wc = 0;
    // {expected sample index, register number, data}
    logic [71:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_all(input string tag);
        chk({tag, "_enable"}, 64'(analyzer_enable), 64'd0);
        chk({tag, "_clear_n"}, 64'(analyzer_clear_n), 64'd1);
        chk({tag, "_index"}, 64'(result_index), 64'd0);
        chk({tag, "_op"}, 64'(register_operation), 64'd0);
        chk({tag, "_regnum"}, 64'(register_number), 64'd0);
        chk({tag, "_wdata"}, 64'(register_write), 64'd0);
        chk({tag, "_irq"}, 64'(irq), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_wcount"}, 64'(window_count), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_table(input bit pattern);
        for (int k = 0; k < 256; k++) begin
            res_tab[k] = pattern ? (32'h100 + 32'(k)) : $urandom;
        end
    endtask

    // Observe one window from its trigger edge until irq. The trigger
    // (single_shot / ack / run) is already applied when this is called.
    // Sample j is taken at the negedge following trigger edge + (j-1).
    // ov_at != 0 injects a single_shot while busy at sample ov_at.
    task automatic observe_window(input int n, input int ov_at);
        int en_n;
        int clr_cnt, clr_first, en_cnt, en_first, en_last, irq_j, budget;
        logic [71:0] e;
        en_n = (n == 0) ? 1 : n;
        clr_cnt = 0; clr_first = 0; en_cnt = 0; en_first = 0; en_last = 0; irq_j = 0;
        budget = en_n + SETTLE + HOLD * NCH + 20;
        exp_q.delete();
        for (int k = 1; k <= NCH; k++) begin
            exp_q.push_back({32'(en_n + SETTLE + 3 + HOLD * (k - 1)), 8'(k), res_tab[k]});
        end
        for (int j = 1; (j <= budget) && (irq_j == 0); j++) begin
            @(negedge clk);
            if (j == 1) begin
                single_shot = 1'b0;
                ack = 1'b0;
                chk("irq_low_after_trigger", 64'(irq), 64'd0);
                chk("busy_after_trigger", 64'(busy), 64'd1);
            end
            if ((ov_at != 0) && (j == ov_at + 1)) begin
                single_shot = 1'b0;
                chk("overrun_set", 64'(overrun), 64'd1);
            end
            if (analyzer_clear_n !== 1'b1) begin
                clr_cnt++;
                if (clr_first == 0) clr_first = j;
            end
            if (analyzer_enable === 1'b1) begin
                en_cnt++;
                if (en_first == 0) en_first = j;
                en_last = j;
            end
            if (register_operation !== 2'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(register_operation), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_op", 64'(register_operation), 64'd2);
                    chk("write_time", 64'(j), 64'(e[71:40]));
                    chk("write_regnum", 64'(register_number), 64'(e[39:32]));
                    chk("write_index", 64'(result_index), 64'(e[39:32]));
                    chk("write_data", 64'(register_write), 64'(e[31:0]));
                end
            end
            if (irq === 1'b1) irq_j = j;
            if ((ov_at != 0) && (j == ov_at)) single_shot = 1'b1;
        end
        chk("clear_cycles", 64'(clr_cnt), 64'd1);
        chk("clear_first", 64'(clr_first), 64'd1);
        chk("enable_cycles", 64'(en_cnt), 64'(en_n));
        chk("enable_first", 64'(en_first), 64'd2);
        chk("enable_last", 64'(en_last), 64'(en_n + 1));
        chk("irq_time", 64'(irq_j), 64'(en_n + SETTLE + 2 + HOLD * NCH));
        chk("writes_missing", 64'(exp_q.size()), 64'd0);
        exp_wc++;
        chk("window_count", 64'(window_count), 64'(16'(exp_wc)));
    endtask

    task automatic do_ack_idle(input string tag);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({tag, "_irq"}, 64'(irq), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int stray;
        bit found;

        fill_table(1'b1);
        repeat (3) @(negedge clk);
        check_reset_all("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_all("idle");

        // Single shot, 10-cycle window, recognisable results.
        window_cycles = 32'd10;
        single_shot = 1'b1;
        observe_window(10, 0);
        do_ack_idle("ack_single");

        // Zero length behaves as one cycle.
        fill_table(1'b0);
        window_cycles = 32'd0;
        single_shot = 1'b1;
        observe_window(0, 0);
        do_ack_idle("ack_zero");

        // Random lengths and results.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 40);
            fill_table(1'b0);
            window_cycles = 32'(n);
            single_shot = 1'b1;
            observe_window(n, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_ack_idle("ack_random");
        end

        // Continuous mode: three windows, ack five cycles after each irq.
        run = 1'b1;
        for (int w = 0; w < 3; w++) begin
            n = $urandom_range(1, 15);
            fill_table(1'b0);
            window_cycles = 32'(n);
            if (w > 0) begin
                repeat (4) @(negedge clk);
                ack = 1'b1;
            end
            observe_window(n, 0);
        end
        repeat (4) @(negedge clk);
        ack = 1'b1;
        run = 1'b0;
        @(negedge clk);
        ack = 1'b0;
        chk("cont_end_irq", 64'(irq), 64'd0);
        chk("cont_end_busy", 64'(busy), 64'd0);

        // Abort in dump slot 3.
        fill_table(1'b0);
        window_cycles = 32'd6;
        single_shot = 1'b1;
        @(negedge clk);
        single_shot = 1'b0;
        found = 1'b0;
        for (int j = 0; (j < 200) && !found; j++) begin
            @(negedge clk);
            if (result_index === 8'd3) found = 1'b1;
        end
        chk("abort_reached_slot3", 64'(found), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_op", 64'(register_operation), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_index", 64'(result_index), 64'd0);
        chk("abort_irq", 64'(irq), 64'd0);
        stray = 0;
        repeat (60) begin
            @(negedge clk);
            if ((register_operation !== 2'd0) || (irq !== 1'b0) || (busy !== 1'b0)) stray++;
        end
        chk("abort_quiet", 64'(stray), 64'd0);
        chk("abort_wcount", 64'(window_count), 64'(16'(exp_wc)));

        // single_shot during MEASURE sets overrun; ack clears it.
        fill_table(1'b0);
        window_cycles = 32'd12;
        single_shot = 1'b1;
        observe_window(12, 4);
        do_ack_idle("ack_overrun");

        // Simultaneous abort and ack in NOTIFY with run high: no new clear.
        fill_table(1'b0);
        window_cycles = 32'd3;
        run = 1'b1;
        observe_window(3, 0);
        abort = 1'b1;
        ack = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ack = 1'b0;
        run = 1'b0;
        chk("abort_ack_busy", 64'(busy), 64'd0);
        chk("abort_ack_clear_n", 64'(analyzer_clear_n), 64'd1);
        chk("abort_ack_irq", 64'(irq), 64'd0);
        @(negedge clk);
        chk("abort_ack_busy2", 64'(busy), 64'd0);
        chk("abort_ack_clear_n2", 64'(analyzer_clear_n), 64'd1);

        // Reset mid-window.
        window_cycles = 32'd20;
        single_shot = 1'b1;
        @(negedge clk);
        single_shot = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_enable", 64'(analyzer_enable), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_enable", 64'(analyzer_enable), 64'd0);
        chk("reset_wcount", 64'(window_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        exp_wc = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_all("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/measurement_window_controller.md
# measurement_window_controller

Sequencer for a bank of frequency analyzers on the AXI clock domain. It clears the analyzers, opens a measurement window of a programmed number of clock cycles and lets them settle. It then serialises the results into the AXI slave register-write interface, one register per slot, raises an interrupt and waits for software acknowledge. It replaces the ad-hoc start/stop/dump logic around the analyzers with one explicit state machine that supports single-shot and continuous runs.

## Interface
- CLOCK_FREQUENCY, 100000000: informational only, no logic depends on it.
- NUMBER_OF_CHANNELS, 7: result registers dumped per window, range 1..255.
- SETTLE_CYCLES, 4: idle cycles after the window closes, before the dump starts; minimum 1.
- HOLD_CYCLES, 4: cycles per dump slot; minimum 1.
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- run  in  1  level: continuous mode while high.
- single_shot  in  1  pulse: one measurement from IDLE.
- abort  in  1  pulse: terminate any activity.
- ack  in  1  pulse: software interrupt acknowledge.
- window_cycles  in  32  window length; sampled in CLEAR; 0 treated as 1.
- result_value  in  32  analyzer result selected by result_index (combinational, outside this block).
- result_index  out  8  channel being dumped (1..NUMBER_OF_CHANNELS), 0 otherwise.
- analyzer_enable  out  1  high for exactly the window length.
- analyzer_clear_n  out  1  active-low analyzer clear.
- register_operation  out  2  2 = write, 0 = none.
- register_number  out  8  target register.
- register_write  out  32  write data.
- irq  out  1  results ready.
- busy  out  1  high in any state except IDLE.
- window_count  out  16  completed windows, wraps at 0xFFFF→0.
- overrun  out  1  sticky: single_shot arrived while busy.

## Operation
- States: IDLE, CLEAR, MEASURE, SETTLE, DUMP, NOTIFY.
- IDLE: on run=1 or single_shot=1 → CLEAR.
- CLEAR: one cycle. analyzer_clear_n=0. Latch window length max(window_cycles,1) into the timer. → MEASURE.
- MEASURE: analyzer_enable=1. Timer decrements each cycle; at count 1 → SETTLE. Result: enable high exactly N cycles. run falling does not shorten the window.
- SETTLE: SETTLE_CYCLES cycles with enable=0. → DUMP with slot k=1.
- DUMP slot k: HOLD_CYCLES cycles.
  - result_index=k and register_number=k for the whole slot.
  - register_write=result_value registered on the slot's first cycle and held.
  - register_operation=2 on the slot's second cycle only (first cycle when HOLD_CYCLES=1), 0 otherwise.
  - After slot NUMBER_OF_CHANNELS → NOTIFY.
- NOTIFY: irq=1. window_count increments once on entry. On ack → CLEAR if run=1, else IDLE. ack outside NOTIFY is ignored. overrun is cleared on ack in any state.
- abort in any state → IDLE next cycle: all outputs return to reset values except window_count and overrun. Priority: abort > ack > run/single_shot.
- single_shot while busy: ignored; sets overrun.

## Timing
- Reset values of all outputs: analyzer_clear_n=1; every other output 0.
- All outputs are registered; no combinational input→output path.
- single_shot sampled at edge t → clear_n low during t+1 → enable high t+2 … t+N+1.
- First register write appears at t+N+SETTLE_CYCLES+3 (HOLD_CYCLES>1).
- irq rises HOLD_CYCLES·NUMBER_OF_CHANNELS cycles after the dump starts.
- ack at edge a → irq low at a+1. Continuous mode: clear_n low at a+1.
- Reset asserted mid-operation: immediate return to the reset values, including window_count and overrun.

## Structure
- Shared package frequency_analyzer_pkg holds:
  - state encoding (3-bit);
  - REGISTER_WRITE_OPERATION=2 and REGISTER_NO_OPERATION=0, also used by axi_slave_impl and its users.
- Sub-module measurement_timer: 32-bit loadable down counter with load, enable and terminal-count outputs. It is reused for the SETTLE and HOLD counts with a smaller width parameter.
- Main FSM, slot counter and output registers stay in this module.

## Test plan
- single_shot, window_cycles=10, defaults:
  - enable high exactly 10 cycles;
  - 7 writes to registers 1..7 with result_value=0x100+index, each operation pulse 1 cycle, 4 cycles apart;
  - irq high, window_count=1.
- window_cycles=0 → enable high exactly 1 cycle; full dump follows.
- run held high, ack 5 cycles after each irq:
  - three consecutive windows, each preceded by a 1-cycle clear_n low;
  - window_count=3.
- abort during DUMP slot 3:
  - register_operation=0 next cycle; no further writes; irq never rises;
  - busy=0, window_count unchanged.
- single_shot during MEASURE → overrun=1, window length unaffected; overrun=0 after the next ack. Simultaneous abort and ack in NOTIFY → IDLE, no CLEAR even with run=1.
- Reset asserted in MEASURE:
  - enable=0 immediately, window_count=0;
  - after release, with run=0, outputs stay at their reset values.
